// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants, opcodes and fetch state encoding for the 16-bit CPU
package cpu_pkg;

  localparam logic [15:0] NOP_INSTR  = 16'h0000;
  localparam logic [3:0]  HLT_OPCODE = 4'hF;

  localparam logic [3:0]  OP_ADD = 4'h0;
  localparam logic [3:0]  OP_SUB = 4'h1;
  localparam logic [3:0]  OP_LW  = 4'h8;
  localparam logic [3:0]  OP_SW  = 4'h9;
  localparam logic [3:0]  OP_BEQ = 4'hC;
  localparam logic [3:0]  OP_JMP = 4'hD;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } fetch_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - pipeline register with hold and flush/bubble, reusable between stages
module if_id_reg #(
  parameter int                 INSTR_W   = 16,
  parameter int                 ADDR_W    = 16,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hold_i,
  input  logic               flush_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [ADDR_W-1:0]  pc_plus2_i,
  input  logic               valid_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc_plus2_o,
  output logic               valid_o
);

  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  pc_plus2_q;
  logic               valid_q;

  // Hold wins over flush so a stalled stage keeps its contents intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q    <= NOP_INSTR;
      pc_plus2_q <= '0;
      valid_q    <= 1'b0;
    end else if (hold_i) begin
      instr_q    <= instr_q;
      pc_plus2_q <= pc_plus2_q;
      valid_q    <= valid_q;
    end else if (flush_i) begin
      instr_q    <= NOP_INSTR;
      pc_plus2_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_i;
      pc_plus2_q <= pc_plus2_i;
      valid_q    <= valid_i;
    end
  end

  assign instr_o    = instr_q;
  assign pc_plus2_o = pc_plus2_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_if_id_stage.sv
// rtl/fetch_if_id_stage.sv - PC, fetch FSM and IF/ID register; FETCH_PERF_CNT_EN adds perf counters
module fetch_if_id_stage #(
  parameter int                 ADDR_W     = 16,
  parameter int                 INSTR_W    = 16,
  parameter logic [INSTR_W-1:0] NOP_INSTR  = cpu_pkg::NOP_INSTR,
  parameter logic [3:0]         HLT_OPCODE = cpu_pkg::HLT_OPCODE,
  parameter logic [ADDR_W-1:0]  RESET_PC   = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               imem_valid,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc_plus2,
  output logic               if_id_valid,
  output logic               fetch_halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]        perf_stall_cycles,
  output logic [15:0]        perf_bubble_cycles,
  output logic [15:0]        perf_flush_count
`endif
);

  import cpu_pkg::*;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_plus2;
  logic              req_q, halted_q;
  logic              redirect, is_hlt, hold, flush;

  assign redirect = branch_taken & ~stall;
  assign is_hlt   = (imem_data[INSTR_W-1 -: 4] == HLT_OPCODE);
  assign pc_plus2 = pc_q + ADDR_W'(2);

  // req_q is low only in HALT and in the first cycle after reset, when no
  // request has been issued yet and any imem_valid cannot belong to us.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hold    = 1'b0;
    flush   = 1'b1;
    if (redirect) begin
      pc_d    = branch_target;
      state_d = (state_q == WAIT && !imem_valid) ? DRAIN : FETCH;
    end else if (stall) begin
      hold = 1'b1;
    end else begin
      case (state_q)
        FETCH, WAIT: begin
          if (req_q && imem_valid) begin
            flush = 1'b0;
            if (is_hlt) begin
              state_d = HALT;
            end else begin
              pc_d    = pc_plus2;
              state_d = FETCH;
            end
          end else if (req_q) begin
            state_d = WAIT;
          end
        end
        DRAIN: begin
          if (imem_valid) state_d = FETCH;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      req_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_q    <= (state_d != HALT);
      halted_q <= (state_d == HALT);
    end
  end

  assign imem_req     = req_q;
  assign imem_addr    = pc_q;
  assign fetch_halted = halted_q;

  if_id_reg #(
    .INSTR_W   (INSTR_W),
    .ADDR_W    (ADDR_W),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .hold_i     (hold),
    .flush_i    (flush),
    .instr_i    (imem_data),
    .pc_plus2_i (pc_plus2),
    .valid_i    (1'b1),
    .instr_o    (if_id_instr),
    .pc_plus2_o (if_id_pc_plus2),
    .valid_o    (if_id_valid)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cnt_q, bubble_cnt_q, flush_cnt_q;
  logic        bubble_evt;

  // Flush bubbles and the post-reset idle cycle are not counted as bubbles.
  assign bubble_evt = ~redirect & ~stall & flush & (req_q | (state_q == HALT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      if (stall && !redirect) stall_cnt_q <= sat_inc16(stall_cnt_q);
      if (bubble_evt)         bubble_cnt_q <= sat_inc16(bubble_cnt_q);
      if (redirect)           flush_cnt_q <= sat_inc16(flush_cnt_q);
    end
  end

  assign perf_stall_cycles  = stall_cnt_q;
  assign perf_bubble_cycles = bubble_cnt_q;
  assign perf_flush_count   = flush_cnt_q;
`endif

endmodule

// File: doc/fetch_if_id_stage.md
Name: fetch_if_id_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register for the 16-bit pipelined CPU.
- Owns the PC and drives the instruction-memory/cache request.
- Consumes `stall` from the hazard detection unit and the branch redirect resolved in ID.
- Produces the IF/ID fields (instruction, PC+2, valid) that decode and hazard detection read.

Parameters:
- ADDR_W, 16, PC / memory address width
- INSTR_W, 16, instruction width
- NOP_INSTR, 16'h0000, instruction value loaded into IF/ID on a bubble or flush
- HLT_OPCODE, 4'hF, opcode (instr[15:12]) that halts fetch
- RESET_PC, 16'h0000, PC value after reset

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hazard stall; hold PC and IF/ID
- branch_taken  in  1  branch/jump resolved taken in ID this cycle
- branch_target  in  ADDR_W  redirect address, valid with branch_taken
- imem_req  out  1  fetch request to I-memory/cache
- imem_addr  out  ADDR_W  fetch address (= PC)
- imem_data  in  INSTR_W  returned instruction
- imem_valid  in  1  imem_data valid for imem_addr this cycle
- if_id_instr  out  INSTR_W  IF/ID instruction
- if_id_pc_plus2  out  ADDR_W  IF/ID PC+2
- if_id_valid  out  1  IF/ID holds a real instruction
- fetch_halted  out  1  fetch stopped on HLT

Behaviour:
- Reset (async, rst_n=0):
  - PC=RESET_PC, state=FETCH
  - if_id_instr=NOP_INSTR, if_id_pc_plus2=0, if_id_valid=0, fetch_halted=0, imem_req=0.
  - Fetch restarts on the first edge after deassertion.
- imem_req=1 in FETCH and WAIT, also in DRAIN; imem_req=0 in HALT.
- imem_addr=PC always.
- Redirect: redirect = branch_taken & ~stall.
  - branch_taken while stall=1 is ignored; the hazard unit re-presents it once stall clears.
- Priority per edge: redirect > stall > normal fetch.
- Redirect, any state:
  - PC<=branch_target; IF/ID<=NOP, valid=0 (flush).
  - Next state is FETCH, except from WAIT (imem_valid=0) where next state is DRAIN, discarding one response.
- Stall (no redirect):
  - PC, IF/ID and state hold.
  - imem_valid during stall is ignored; the same address is re-fetched.
- FETCH/WAIT with imem_valid=1:
  - IF/ID<={imem_data, PC+2, 1}.
  - If imem_data[15:12]==HLT_OPCODE: PC holds, next state=HALT. Otherwise PC<=PC+2 (mod 2^16, wraps 0xFFFE->0x0000), next state=FETCH.
- FETCH/WAIT with imem_valid=0: IF/ID<=bubble (NOP, valid 0), PC holds, next state=WAIT.
- DRAIN:
  - imem_valid=1: response discarded, bubble inserted, next state=FETCH (fetch from the new PC).
  - imem_valid=0: stay in DRAIN, bubble.
- HALT:
  - fetch_halted=1, PC frozen, IF/ID<=bubble unless stalled.
  - Exit only on redirect (a speculative HLT behind a taken branch), going to FETCH.
- Latency: a hit returns the instruction in IF/ID one edge after the address is presented; throughput is 1 instr/cycle.
- Reset mid-WAIT/DRAIN: any outstanding response is abandoned; the memory side must tolerate a changed address.

Optional Feature:
- FETCH_PERF_CNT_EN defined:
  - Adds outputs perf_stall_cycles[15:0], perf_bubble_cycles[15:0] and perf_flush_count[15:0].
  - All are saturating at 16'hFFFF and cleared by rst_n.
  - They count stall-held cycles, bubbles from miss/DRAIN/HALT, and redirects respectively.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package cpu_pkg: NOP_INSTR, HLT_OPCODE, opcode constants, and the fetch state enum {FETCH, WAIT, DRAIN, HALT} as a 2-bit typedef.
- One sub-module, if_id_reg: the pipeline register with hold (stall) and flush/bubble inputs, reused for later stage registers.
- The FSM and PC live in the top.

Test Plan:
- Reset then imem_valid=1 every cycle with instrs 0x1234, 0x2345 -> imem_addr 0x0000, 0x0002, 0x0004; IF/ID shows 0x1234/pc_plus2 0x0002 one edge after each fetch; valid=1.
- stall=1 for 3 cycles at PC=0x0004 -> PC and IF/ID unchanged for 3 edges; next edge continues from 0x0004.
- branch_taken=1 with target 0x0040, stall=0 -> next PC=0x0040, IF/ID=NOP, valid=0. The same stimulus with stall=1 -> no redirect.
- imem_valid=0 for 2 cycles at 0x0008, redirect to 0x0100 in the second cycle, then a response -> state DRAIN, response discarded, next fetch at 0x0100.
- Fetch 0xF000 at 0x000A -> IF/ID valid HLT, then fetch_halted=1, PC stays 0x000A, imem_req=0. A following redirect to 0x0020 resumes fetch.
- PC=0xFFFE hit -> PC wraps to 0x0000, if_id_pc_plus2=0x0000.
